// File: rtl/paridad_pkg.sv
// Shared state encoding and default parameter values for the streaming XOR/parity engine.
package paridad_pkg;

    localparam int unsigned ANCHO_DEF         = 8;
    localparam int unsigned LONG_MAX_DEF      = 16;
    localparam int unsigned PARIDAD_IMPAR_DEF = 0;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ACUMULA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/paridad_xor_flujo_xor_reduccion.sv
// Combinational word-to-parity reduction; the parity sense is fixed by PARIDAD_IMPAR.
module xor_reduccion
    import paridad_pkg::*;
#(
    parameter int unsigned ANCHO         = ANCHO_DEF,
    parameter int unsigned PARIDAD_IMPAR = PARIDAD_IMPAR_DEF
) (
    input  logic [ANCHO-1:0] palabra,
    output logic             paridad
);

    localparam logic IMPAR = (PARIDAD_IMPAR != 0);

    always_comb begin
        paridad = (^palabra) ^ IMPAR;
    end

endmodule

// File: rtl/paridad_xor_flujo.sv
// Streaming XOR/parity engine: folds a packet of words into one XOR word and parity bit,
// or checks a packet whose last word is its XOR check word.
module paridad_xor_flujo
    import paridad_pkg::*;
#(
    parameter int unsigned ANCHO         = ANCHO_DEF,
    parameter int unsigned LONG_MAX      = LONG_MAX_DEF,
    parameter int unsigned PARIDAD_IMPAR = PARIDAD_IMPAR_DEF
) (
    input  logic                          Reloj,
    input  logic                          Reset_n,
    input  logic [ANCHO-1:0]              Entrada,
    input  logic                          Entrada_valida,
    input  logic                          Ultimo,
    input  logic                          Modo,
    output logic                          Entrada_lista,
    output logic [ANCHO-1:0]              Salida_palabra,
    output logic                          Salida_bit,
    output logic                          Error_paridad,
    output logic                          Desborde,
    output logic [$clog2(LONG_MAX+1)-1:0] Cuenta,
    output logic                          Salida_valida,
    input  logic                          Salida_lista
);

    localparam int unsigned CW = $clog2(LONG_MAX + 1);
    localparam logic [CW-1:0] LONG_MAX_C = CW'(LONG_MAX);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] acc_q, acc_d;
    logic [CW-1:0]    cuenta_q, cuenta_d;
    logic             modo_q, modo_d;
    logic             desborde_q, desborde_d;
    logic             bit_q, bit_d;
    logic             error_q, error_d;
    logic             paridad_d;
    logic             acepta;

    // Parity is taken from the next accumulator value so the registered bit lands with the result.
    xor_reduccion #(
        .ANCHO         (ANCHO),
        .PARIDAD_IMPAR (PARIDAD_IMPAR)
    ) u_xor_reduccion (
        .palabra (acc_d),
        .paridad (paridad_d)
    );

    always_comb begin
        estado_d   = estado_q;
        acc_d      = acc_q;
        cuenta_d   = cuenta_q;
        modo_d     = modo_q;
        desborde_d = desborde_q;
        acepta     = Entrada_valida && (estado_q != ENTREGA);

        case (estado_q)
            ESPERA, ACUMULA: begin
                if (acepta) begin
                    if (estado_q == ESPERA) begin
                        acc_d    = Entrada;
                        cuenta_d = CW'(1);
                        modo_d   = Modo;
                    end else begin
                        acc_d    = acc_q ^ Entrada;
                        cuenta_d = cuenta_q + CW'(1);
                    end
                    if (Ultimo) begin
                        estado_d = ENTREGA;
                    end else if (cuenta_d == LONG_MAX_C) begin
                        estado_d   = ENTREGA;
                        desborde_d = 1'b1;
                    end else begin
                        estado_d = ACUMULA;
                    end
                end
            end
            ENTREGA: begin
                if (Salida_lista) begin
                    estado_d   = ESPERA;
                    acc_d      = '0;
                    cuenta_d   = '0;
                    modo_d     = 1'b0;
                    desborde_d = 1'b0;
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase

        // Status bits are only meaningful while a result is held; zero otherwise.
        bit_d   = (estado_d == ENTREGA) && paridad_d;
        error_d = (estado_d == ENTREGA) && modo_d && (acc_d != '0);
    end

    always_ff @(posedge Reloj) begin
        if (!Reset_n) begin
            estado_q   <= ESPERA;
            acc_q      <= '0;
            cuenta_q   <= '0;
            modo_q     <= 1'b0;
            desborde_q <= 1'b0;
            bit_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            acc_q      <= acc_d;
            cuenta_q   <= cuenta_d;
            modo_q     <= modo_d;
            desborde_q <= desborde_d;
            bit_q      <= bit_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        Entrada_lista  = (estado_q != ENTREGA);
        Salida_valida  = (estado_q == ENTREGA);
        Salida_palabra = acc_q;
        Salida_bit     = bit_q;
        Error_paridad  = error_q;
        Desborde       = desborde_q;
        Cuenta         = cuenta_q;
    end

endmodule

// File: tb/tb_paridad_xor_flujo.sv
// Directed self-checking bench for paridad_xor_flujo (ANCHO=8, LONG_MAX=16), even and odd parity instances.
module tb_paridad_xor_flujo;

    logic       reloj;
    logic       reset_n;
    logic [7:0] entrada;
    logic       entrada_valida;
    logic       ultimo;
    logic       modo;
    logic       salida_lista;

    logic       entrada_lista,  entrada_lista_i;
    logic [7:0] salida_palabra, salida_palabra_i;
    logic       salida_bit,     salida_bit_i;
    logic       error_paridad,  error_paridad_i;
    logic       desborde,       desborde_i;
    logic [4:0] cuenta,         cuenta_i;
    logic       salida_valida,  salida_valida_i;

    int unsigned checks = 0;
    int unsigned errores = 0;

    paridad_xor_flujo #(
        .ANCHO         (8),
        .LONG_MAX      (16),
        .PARIDAD_IMPAR (0)
    ) u_dut (
        .Reloj          (reloj),
        .Reset_n        (reset_n),
        .Entrada        (entrada),
        .Entrada_valida (entrada_valida),
        .Ultimo         (ultimo),
        .Modo           (modo),
        .Entrada_lista  (entrada_lista),
        .Salida_palabra (salida_palabra),
        .Salida_bit     (salida_bit),
        .Error_paridad  (error_paridad),
        .Desborde       (desborde),
        .Cuenta         (cuenta),
        .Salida_valida  (salida_valida),
        .Salida_lista   (salida_lista)
    );

    paridad_xor_flujo #(
        .ANCHO         (8),
        .LONG_MAX      (16),
        .PARIDAD_IMPAR (1)
    ) u_dut_impar (
        .Reloj          (reloj),
        .Reset_n        (reset_n),
        .Entrada        (entrada),
        .Entrada_valida (entrada_valida),
        .Ultimo         (ultimo),
        .Modo           (modo),
        .Entrada_lista  (entrada_lista_i),
        .Salida_palabra (salida_palabra_i),
        .Salida_bit     (salida_bit_i),
        .Error_paridad  (error_paridad_i),
        .Desborde       (desborde_i),
        .Cuenta         (cuenta_i),
        .Salida_valida  (salida_valida_i),
        .Salida_lista   (salida_lista)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic comprobar(input string tag, input logic [31:0] obtenido, input logic [31:0] esperado);
        checks++;
        if (obtenido !== esperado) begin
            errores++;
            $display("FAIL %s: obtenido=0x%0h esperado=0x%0h", tag, obtenido, esperado);
        end
    endtask

    // Starts and ends on a falling edge; waits (bounded) for Entrada_lista before the accepting edge.
    task automatic enviar(input logic [7:0] palabra, input logic ult, input logic md);
        int unsigned espera;
        entrada        = palabra;
        ultimo         = ult;
        modo           = md;
        entrada_valida = 1'b1;
        espera         = 0;
        while (!entrada_lista && espera < 50) begin
            @(posedge reloj);
            @(negedge reloj);
            espera++;
        end
        if (espera >= 50) comprobar("timeout_entrada_lista", 32'(entrada_lista), 32'd1);
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        ultimo         = 1'b0;
        modo           = 1'b0;
    endtask

    task automatic liberar(input string tag);
        salida_lista = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        salida_lista = 1'b0;
        comprobar({tag, "_valida_baja"}, 32'(salida_valida), 32'd0);
        comprobar({tag, "_cuenta_cero"}, 32'(cuenta), 32'd0);
        comprobar({tag, "_desborde_cero"}, 32'(desborde), 32'd0);
        comprobar({tag, "_palabra_cero"}, 32'(salida_palabra), 32'd0);
        comprobar({tag, "_lista"}, 32'(entrada_lista), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: obtenido=timeout esperado=fin");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] palabra_ret;
        logic [4:0] cuenta_ret;

        reset_n        = 1'b0;
        entrada        = 8'h00;
        entrada_valida = 1'b0;
        ultimo         = 1'b0;
        modo           = 1'b0;
        salida_lista   = 1'b0;
        @(posedge reloj);
        @(negedge reloj);
        comprobar("reset_lista", 32'(entrada_lista), 32'd1);
        comprobar("reset_valida", 32'(salida_valida), 32'd0);
        comprobar("reset_palabra", 32'(salida_palabra), 32'd0);
        comprobar("reset_bit", 32'(salida_bit), 32'd0);
        comprobar("reset_bit_impar", 32'(salida_bit_i), 32'd0);
        comprobar("reset_cuenta", 32'(cuenta), 32'd0);
        comprobar("reset_error", 32'(error_paridad), 32'd0);
        comprobar("reset_desborde", 32'(desborde), 32'd0);
        reset_n = 1'b1;

        // 1: generate mode
        enviar(8'h01, 1'b0, 1'b0);
        comprobar("t1_valida_parcial", 32'(salida_valida), 32'd0);
        enviar(8'h02, 1'b0, 1'b0);
        enviar(8'h04, 1'b1, 1'b0);
        comprobar("t1_valida", 32'(salida_valida), 32'd1);
        comprobar("t1_palabra", 32'(salida_palabra), 32'h07);
        comprobar("t1_bit", 32'(salida_bit), 32'd1);
        comprobar("t1_bit_impar", 32'(salida_bit_i), 32'd0);
        comprobar("t1_cuenta", 32'(cuenta), 32'd3);
        comprobar("t1_error", 32'(error_paridad), 32'd0);
        comprobar("t1_desborde", 32'(desborde), 32'd0);
        comprobar("t1_lista", 32'(entrada_lista), 32'd0);
        liberar("t1");

        // 2: check mode, good then bad check word
        enviar(8'h5A, 1'b0, 1'b1);
        enviar(8'h3C, 1'b0, 1'b0);
        enviar(8'h66, 1'b1, 1'b0);
        comprobar("t2a_valida", 32'(salida_valida), 32'd1);
        comprobar("t2a_error", 32'(error_paridad), 32'd0);
        comprobar("t2a_cuenta", 32'(cuenta), 32'd3);
        comprobar("t2a_palabra", 32'(salida_palabra), 32'h00);
        liberar("t2a");
        enviar(8'h5A, 1'b0, 1'b1);
        enviar(8'h3C, 1'b0, 1'b0);
        enviar(8'h67, 1'b1, 1'b0);
        comprobar("t2b_error", 32'(error_paridad), 32'd1);
        comprobar("t2b_palabra", 32'(salida_palabra), 32'h01);
        comprobar("t2b_bit", 32'(salida_bit), 32'd1);
        liberar("t2b");

        // 3: overflow at LONG_MAX
        for (int i = 0; i < 16; i++) begin
            enviar(8'h11, 1'b0, 1'b0);
        end
        comprobar("t3_valida", 32'(salida_valida), 32'd1);
        comprobar("t3_desborde", 32'(desborde), 32'd1);
        comprobar("t3_cuenta", 32'(cuenta), 32'd16);
        comprobar("t3_palabra", 32'(salida_palabra), 32'h00);
        entrada        = 8'h33;
        entrada_valida = 1'b1;
        ultimo         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge reloj);
            @(negedge reloj);
            comprobar("t3_retenida_lista", 32'(entrada_lista), 32'd0);
            comprobar("t3_retenida_cuenta", 32'(cuenta), 32'd16);
        end
        salida_lista = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        salida_lista = 1'b0;
        comprobar("t3_lib_valida", 32'(salida_valida), 32'd0);
        comprobar("t3_lib_cuenta", 32'(cuenta), 32'd0);
        comprobar("t3_lib_desborde", 32'(desborde), 32'd0);
        @(posedge reloj);
        @(negedge reloj);
        entrada_valida = 1'b0;
        ultimo         = 1'b0;
        comprobar("t3_w17_valida", 32'(salida_valida), 32'd1);
        comprobar("t3_w17_cuenta", 32'(cuenta), 32'd1);
        comprobar("t3_w17_palabra", 32'(salida_palabra), 32'h33);
        liberar("t3");

        // 4: backpressure
        enviar(8'hC3, 1'b1, 1'b0);
        palabra_ret    = salida_palabra;
        cuenta_ret     = cuenta;
        comprobar("t4_palabra", 32'(palabra_ret), 32'hC3);
        entrada_valida = 1'b1;
        for (int i = 0; i < 5; i++) begin
            entrada = (i % 2 == 0) ? 8'hFF : 8'h0F;
            @(posedge reloj);
            @(negedge reloj);
            comprobar("t4_palabra_estable", 32'(salida_palabra), 32'hC3);
            comprobar("t4_cuenta_estable", 32'(cuenta), 32'(cuenta_ret));
            comprobar("t4_valida", 32'(salida_valida), 32'd1);
            comprobar("t4_lista", 32'(entrada_lista), 32'd0);
            comprobar("t4_bit", 32'(salida_bit), 32'd0);
        end
        entrada_valida = 1'b0;
        liberar("t4");

        // 5: reset mid-packet
        enviar(8'h12, 1'b0, 1'b0);
        enviar(8'h34, 1'b0, 1'b0);
        comprobar("t5_cuenta_previa", 32'(cuenta), 32'd2);
        reset_n = 1'b0;
        @(posedge reloj);
        @(negedge reloj);
        reset_n = 1'b1;
        comprobar("t5_cuenta_reset", 32'(cuenta), 32'd0);
        comprobar("t5_palabra_reset", 32'(salida_palabra), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge reloj);
            @(negedge reloj);
            comprobar("t5_sin_resultado", 32'(salida_valida), 32'd0);
        end
        enviar(8'hFF, 1'b1, 1'b0);
        comprobar("t5_valida", 32'(salida_valida), 32'd1);
        comprobar("t5_palabra", 32'(salida_palabra), 32'hFF);
        comprobar("t5_bit", 32'(salida_bit), 32'd0);
        comprobar("t5_bit_impar", 32'(salida_bit_i), 32'd1);
        comprobar("t5_cuenta", 32'(cuenta), 32'd1);
        liberar("t5");

        // 6: gaps and Modo ignored after first word
        enviar(8'hA0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            entrada = 8'h55;
            @(posedge reloj);
            @(negedge reloj);
            comprobar("t6_hueco_cuenta", 32'(cuenta), 32'd1);
            comprobar("t6_hueco_palabra", 32'(salida_palabra), 32'hA0);
        end
        enviar(8'h0A, 1'b1, 1'b1);
        comprobar("t6_palabra", 32'(salida_palabra), 32'hAA);
        comprobar("t6_cuenta", 32'(cuenta), 32'd2);
        comprobar("t6_error", 32'(error_paridad), 32'd0);
        comprobar("t6_bit", 32'(salida_bit), 32'd0);
        comprobar("t6_bit_impar", 32'(salida_bit_i), 32'd1);
        liberar("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errores);
        $finish;
    end

endmodule
